regfile_wb_ctrl: RTL
====================

# regfile_wb_ctrl

Writeback controller and register scoreboard that owns the single write port of the general register file. It merges single-cycle pipeline results with out-of-order results from the multi-cycle multiply/divide unit. It buffers the multiply/divide results in a small FIFO and tracks destination registers with outstanding long-latency writes. It sits between the execute/memory stages and the register file's `wen`/`regWAddr`/`regWData` port, and feeds a hazard stall to decode.

## Interface
Parameters:
- `MD_DEPTH`, 2: depth of the multiply/divide result FIFO; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `pipe_wen`  in  1  pipeline writeback valid this cycle; always accepted, never back-pressured.
- `pipe_rd`  in  5  pipeline destination register.
- `pipe_wdata`  in  32  pipeline result.
- `md_valid`  in  1  multiply/divide result valid.
- `md_ready`  out  1  FIFO can accept; equals not-full.
- `md_rd`  in  5  multiply/divide destination.
- `md_wdata`  in  32  multiply/divide result.
- `issue_md`  in  1  decode issued a multiply/divide op this cycle; already qualified by `!hazard_stall`.
- `issue_rd`  in  5  destination of the issued multiply/divide op.
- `rs1`, `rs2`, `id_rd`  in  5 each  register addresses of the instruction in decode.
- `hazard_stall`  out  1  combinational; decode must hold.
- `wen`  out  1  register-file write enable (registered).
- `regWAddr`  out  5  register-file write address (registered).
- `regWData`  out  32  register-file write data (registered).

## Operation
- **Output register.**
  - `wen`, `regWAddr` and `regWData` are loaded every cycle from the selected source.
  - The register file commits on the following edge and bypasses the same-cycle read, so consumers see the value in the cycle `wen` is high.
- **Source priority.**
  - When `pipe_wen` is high, the pipeline source wins.
  - When `pipe_wen` is low and the FIFO is non-empty, the FIFO head is popped.
  - Otherwise `wen` is loaded with 0.
  - `regWAddr` and `regWData` hold their last values while `wen` is 0.
- **x0 writes.**
  - Any selected write with rd = 0 loads `wen` = 0.
  - A FIFO entry with rd = 0 is still popped.
- **FIFO.**
  - Push on `md_valid & md_ready`. `md_ready = (count != MD_DEPTH)`.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Read and write pointers wrap modulo `MD_DEPTH`.
  - There is no FIFO bypass: every multiply/divide result spends at least one cycle in the FIFO.
- **Scoreboard.**
  - `pending` is a 32-bit vector; bit 0 is hardwired to 0.
  - Set: bit `issue_rd` on `issue_md` (rd ≠ 0).
  - Clear: bit rd when a FIFO entry is popped into the output register.
  - Set and clear of the same bit in the same cycle: set wins.
  - Clears of one bit cover all entries with that rd; a second issue to a pending rd cannot occur because of the stall rule below.
- **Hazard.**
  - `hazard_stall = pending[rs1] | pending[rs2] | pending[id_rd]`.
  - This covers RAW hazards and WAW hazards against outstanding multiply/divide writes.
  - It is purely combinational on current state.

## Timing
- **Reset values:** `wen` = 0, `regWAddr` = 0, `regWData` = 0, `md_ready` = 1, `hazard_stall` = 0, FIFO empty, `pending` = 0.
- **Reset mid-operation:** reset asserted at any time discards FIFO contents and pending bits. The next write after reset release comes only from new inputs.
- **Pipeline latency:** `pipe_wen` sampled at edge N gives `wen` high during cycle N+1.
- **Multiply/divide latency:** accepted at edge N, popped at edge N+1 at the earliest. `wen` is high in cycle N+2. The `pending` bit is low from cycle N+2.
- **Back-pressure:** with continuous `pipe_wen` the FIFO never drains. `md_ready` drops once count reaches `MD_DEPTH` and recovers the cycle after the first pop.
- **Producer handshake:** the multiply/divide producer must hold `md_valid`, `md_rd` and `md_wdata` stable until `md_ready` is high.

## Test plan
- **Reset:** assert `reset` mid-stream with 2 FIFO entries and pending bits 5 and 7 → all outputs are at reset values immediately, `hazard_stall` = 0, no writes follow release.
- **Pipeline write:** `pipe_wen`=1, `pipe_rd`=3, `pipe_wdata`=0xDEADBEEF at edge N → cycle N+1 shows `wen`=1, `regWAddr`=3, `regWData`=0xDEADBEEF. The same stimulus with `pipe_rd`=0 gives `wen`=0.
- **Scoreboard round trip:** `issue_md` with `issue_rd`=9, then `rs1`=9 → `hazard_stall`=1. Then `md_valid` with rd=9, data 0x12345678 and no pipeline traffic → write to x9 two cycles after acceptance, `hazard_stall` low in that write cycle.
- **Priority/full:** hold `pipe_wen`=1 for 6 cycles while `md_valid` offers rd 10, 11, 12 → `md_ready` drops after 2 accepts. When `pipe_wen` falls, x10 is written, then x11, then x12 in consecutive cycles, in order.
- **Simultaneous push/pop at wrap:** keep the FIFO at count 1 across 5 push+pop cycles → count stays 1, data order is preserved across pointer wrap.
- **Set/clear collision:** pop an entry with rd=4 in the same cycle as `issue_md` with `issue_rd`=4 → `pending[4]` remains 1.

Source files
------------

// File: rtl/regfile_wb_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_wb_ctrl
//
// Purpose:
//   Owns the single write port of the general register file. Single-cycle
//   pipeline results always win the port. Multiply/divide results arrive out of
//   order, wait in a small FIFO and drain whenever the pipeline leaves the port
//   idle. A scoreboard of destination registers with outstanding
//   multiply/divide writes drives a combinational hazard stall back to decode.
//
// Ports:
//   clk, reset          single clock; asynchronous active-high reset
//   pipe_wen/rd/wdata   pipeline writeback; always accepted
//   md_valid/rd/wdata   multiply/divide result; accepted when md_ready
//   md_ready            result FIFO not full
//   issue_md, issue_rd  decode issued a multiply/divide op to issue_rd
//   rs1, rs2, id_rd     register addresses of the instruction in decode
//   hazard_stall        decode must hold (RAW/WAW against pending md writes)
//   wen/regWAddr/regWData  registered register-file write port
// -----------------------------------------------------------------------------
module regfile_wb_ctrl #(
    parameter int MD_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        pipe_wen,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_wdata,

    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_wdata,

    input  logic        issue_md,
    input  logic [4:0]  issue_rd,

    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  id_rd,
    output logic        hazard_stall,

    output logic        wen,
    output logic [4:0]  regWAddr,
    output logic [31:0] regWData
);

    localparam int PTR_W = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MD_DEPTH);

    // -------------------------------------------------------------------------
    // Multiply/divide result FIFO
    // -------------------------------------------------------------------------
    logic [4:0]       fifo_rd_mem   [MD_DEPTH];
    logic [31:0]      fifo_data_mem [MD_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [4:0]       head_rd;
    logic [31:0]      head_data;

    assign fifo_empty = (count_q == '0);
    assign md_ready   = (count_q != FULL_CNT);
    assign push       = md_valid & md_ready;
    // The pipeline owns the port whenever it writes; the FIFO only drains
    // into idle cycles. No bypass: an entry pushed this edge is not visible
    // at the head until the next cycle.
    assign pop        = ~pipe_wen & ~fifo_empty;

    // The head must be readable in the same cycle it is popped so the output
    // register can load it at the pop edge; the FIFO is tiny, so a
    // combinational read of the array is used here.
    assign head_rd    = fifo_rd_mem[rd_ptr_q];
    assign head_data  = fifo_data_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset: stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_mem[wr_ptr_q]   <= md_rd;
            fifo_data_mem[wr_ptr_q] <= md_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Pending-write scoreboard
    // -------------------------------------------------------------------------
    logic [31:0] pending_q, pending_d;

    // x0 is never pending: writes to it are discarded.
    assign pending_d[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_pending
            logic set_bit;
            logic clr_bit;
            assign set_bit = issue_md & (issue_rd == 5'(gi));
            assign clr_bit = pop & (head_rd == 5'(gi));
            // A new issue to the register being retired this cycle keeps the
            // bit set, so the set term is ORed after the clear.
            assign pending_d[gi] = set_bit | (pending_q[gi] & ~clr_bit);
        end
    endgenerate

    assign hazard_stall = pending_q[rs1] | pending_q[rs2] | pending_q[id_rd];

    // -------------------------------------------------------------------------
    // Output write-port register
    // -------------------------------------------------------------------------
    logic        wen_q,   wen_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;

    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (pipe_wen) begin
            if (pipe_rd != 5'd0) begin
                wen_d   = 1'b1;
                waddr_d = pipe_rd;
                wdata_d = pipe_wdata;
            end
        end else if (pop) begin
            // An x0 entry is still consumed from the FIFO, but never written.
            if (head_rd != 5'd0) begin
                wen_d   = 1'b1;
                waddr_d = head_rd;
                wdata_d = head_data;
            end
        end
    end

    assign wen      = wen_q;
    assign regWAddr = waddr_q;
    assign regWData = wdata_q;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

endmodule
